// File: rtl/conv_write_ctrl.sv
// Write-side controller for a sliding-window convolution: fills NUM_REG window
// registers one-hot, launches a convolution, then slides by STRIDE samples.
module conv_write_ctrl #(
  parameter int NUM_REG = 15,
  parameter int STRIDE  = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic                             abort,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic                             wr_en,
  output logic [NUM_REG-1:0]               wr_sel,
  output logic                             conv_start,
  input  logic                             conv_done,
  output logic                             frame_done,
  output logic                             err,
  output logic [$clog2(NUM_REG+1)-1:0]     fill_cnt
);

  localparam int CW = $clog2(NUM_REG+1);
  localparam logic [CW-1:0]      FULL        = CW'(NUM_REG);
  localparam logic [CW-1:0]      LAST_STRIDE = CW'(STRIDE-1);
  localparam logic [NUM_REG-1:0] SEL_RST     = {1'b1, {(NUM_REG-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_SLIDE  = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REG-1:0]   wr_sel_q, wr_sel_d;
  logic [CW-1:0]        fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]        stride_q, stride_d;
  logic                 err_q, err_d;
  logic                 last_q, last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (frame_start) state_d = S_FILL;
        S_FILL: begin
          if (wr_en) begin
            if (fill_cnt_q == FULL - CW'(1)) state_d = S_LAUNCH;
            else if (in_last)                state_d = S_IDLE;
          end
        end
        S_LAUNCH: state_d = S_WAIT;
        S_WAIT:   if (conv_done) state_d = last_q ? S_FINISH : S_SLIDE;
        S_SLIDE:  if (wr_en && (stride_q == LAST_STRIDE || in_last)) state_d = S_LAUNCH;
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Abort also drops in_ready so no sample is consumed on the aborting cycle.
  always_comb begin
    in_ready   = 1'b0;
    conv_start = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_FILL, S_SLIDE: in_ready   = ~abort;
      S_LAUNCH:        conv_start = 1'b1;
      S_FINISH:        frame_done = 1'b1;
      default:         ;
    endcase
  end

  assign wr_en = in_valid & in_ready;

  always_comb begin
    wr_sel_d   = wr_sel_q;
    fill_cnt_d = fill_cnt_q;
    stride_d   = stride_q;
    err_d      = err_q;
    last_d     = last_q;
    if (abort) begin
      wr_sel_d   = SEL_RST;
      fill_cnt_d = '0;
      stride_d   = '0;
      last_d     = 1'b0;
    end else begin
      if (wr_en) wr_sel_d = {wr_sel_q[NUM_REG-2:0], wr_sel_q[NUM_REG-1]};
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            wr_sel_d   = SEL_RST;
            fill_cnt_d = '0;
            err_d      = 1'b0;
            last_d     = 1'b0;
          end
        end
        S_FILL: begin
          if (wr_en) begin
            fill_cnt_d = fill_cnt_q + CW'(1);
            last_d     = in_last;
            if (in_last && (fill_cnt_q < FULL - CW'(1))) err_d = 1'b1;
          end
        end
        S_WAIT:   if (conv_done) stride_d = '0;
        S_SLIDE: begin
          if (wr_en) begin
            stride_d = stride_q + CW'(1);
            last_d   = in_last;
          end
        end
        S_FINISH: fill_cnt_d = '0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel_q   <= SEL_RST;
      fill_cnt_q <= '0;
      stride_q   <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      wr_sel_q   <= wr_sel_d;
      fill_cnt_q <= fill_cnt_d;
      stride_q   <= stride_d;
      err_q      <= err_d;
      last_q     <= last_d;
    end
  end

  assign wr_sel   = wr_sel_q;
  assign fill_cnt = fill_cnt_q;
  assign err      = err_q;

endmodule
